pwm_capture: RTL

//   Receive-side counterpart of the PWM generator: samples an external PWM waveform, measures its

---
 rtl/pwm_capture.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period measurement on step-strobed samples
// Optional input deglitch filter: define PWM_CAPTURE_DEGLITCH_EN.
module pwm_capture #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          step,
  input  logic          pwm_in,
  output logic [CW-1:0] high_ticks,
  output logic [CW-1:0] period_ticks,
  output logic          valid,
  output logic          stuck
);

  localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] MAX_M1 = MAX - ONE;

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          sync_q1, sync_q2;
  logic          samp, s, prev, rise, fall, tmo;
  logic [CW-1:0] per_cnt, hi_cnt, per_nxt, hi_nxt;
  logic          pub, pub_stuck;
  logic [CW-1:0] pub_high, pub_per;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pwm_in;
      sync_q2 <= sync_q1;
    end
  end

  assign samp = step & ena;

`ifdef PWM_CAPTURE_DEGLITCH_EN
  logic dg_last, dg_filt;

  // A new level is accepted on the second consecutive sample that shows it.
  assign s = (sync_q2 == dg_last) ? sync_q2 : dg_filt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dg_last <= 1'b0;
      dg_filt <= 1'b0;
    end else if (samp) begin
      dg_last <= sync_q2;
      dg_filt <= s;
    end
  end
`else
  assign s = sync_q2;
`endif

  assign rise = s & ~prev;
  assign fall = ~s & prev;
  // Timeout fires on the sample that would carry per_cnt up to MAX.
  assign tmo  = (per_cnt >= MAX_M1) & ~rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!ena) begin
      state_nxt = ACQ;
    end else if (step) begin
      case (state)
        ACQ: begin
          if (rise) state_nxt = HIGH;
        end
        HIGH: begin
          if (tmo)       state_nxt = ACQ;
          else if (fall) state_nxt = LOW;
        end
        LOW: begin
          if (rise)     state_nxt = HIGH;
          else if (tmo) state_nxt = ACQ;
        end
        default: state_nxt = ACQ;
      endcase
    end
  end

  always_comb begin
    per_nxt   = per_cnt;
    hi_nxt    = hi_cnt;
    pub       = 1'b0;
    pub_stuck = 1'b0;
    pub_high  = hi_cnt;
    pub_per   = per_cnt;
    if (!ena) begin
      per_nxt = '0;
      hi_nxt  = '0;
    end else if (step) begin
      if (rise) begin
        // Counts include the rise sample itself.
        pub     = (state == LOW);
        per_nxt = ONE;
        hi_nxt  = ONE;
      end else if (tmo) begin
        pub       = 1'b1;
        pub_stuck = 1'b1;
        pub_high  = s ? MAX : '0;
        pub_per   = MAX;
        per_nxt   = '0;
        hi_nxt    = '0;
      end else begin
        per_nxt = sat_inc(per_cnt);
        if (state == HIGH && !fall) hi_nxt = sat_inc(hi_cnt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
      prev    <= 1'b1;
    end else begin
      per_cnt <= per_nxt;
      hi_cnt  <= hi_nxt;
      if (samp) prev <= s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_ticks   <= '0;
      period_ticks <= '0;
      stuck        <= 1'b0;
      valid        <= 1'b0;
    end else begin
      valid <= pub;
      if (pub) begin
        high_ticks   <= pub_high;
        period_ticks <= pub_per;
        stuck        <= pub_stuck;
      end
    end
  end

endmodule
